univ_shift_reg: RTL and testbench

Parametrised universal shift register, the successor to the single-direction serial shift register. Adds selectable shift direction, rotate, arithmetic shift, parallel load and clear, plus a shift counter that flags each completed WIDTH-bit frame. It sits between serial links and parallel datapaths, working as SIPO, PISO or bidirectional serial buffer.

---
 rtl/univ_shift_reg.sv | 129 ++++++++++++
 tb/tb_univ_shift_reg.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with frame counter
//
// Purpose:
//   WIDTH-bit register supporting hold, logical shift left/right, rotate
//   left/right, arithmetic shift right, parallel load and clear. A shift
//   counter tracks shift/rotate operations and pulses frame_done for one
//   cycle after every WIDTH-th shift. Usable as SIPO, PISO or bidirectional
//   serial buffer.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   en             in   operation enable; low holds q and bit_cnt
//   mode[2:0]      in   operation select
//   serial_in_lsb  in   bit entering bit 0 on SHL
//   serial_in_msb  in   bit entering bit WIDTH-1 on SHR
//   par_in         in   parallel load data
//   par_out        out  register contents
//   serial_out_msb out  q[WIDTH-1]
//   serial_out_lsb out  q[0]
//   bit_cnt        out  shifts since last load/clear/wrap
//   frame_done     out  one-cycle pulse after WIDTH shifts

module univ_shift_reg #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             serial_in_lsb,
  input  logic             serial_in_msb,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] par_out,
  output logic             serial_out_msb,
  output logic             serial_out_lsb,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             frame_done
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;
  localparam logic [2:0] MODE_ASR  = 3'b111;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_done_q, frame_done_d;
  logic             shift_op;

  always_comb begin
    q_d          = q_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;   // pulse: cleared on every edge unless a wrap happens
    shift_op     = 1'b0;

    if (en) begin
      case (mode)
        MODE_HOLD: ;
        MODE_SHL: begin
          q_d      = {q_q[WIDTH-2:0], serial_in_lsb};
          shift_op = 1'b1;
        end
        MODE_SHR: begin
          q_d      = {serial_in_msb, q_q[WIDTH-1:1]};
          shift_op = 1'b1;
        end
        MODE_ROL: begin
          q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          shift_op = 1'b1;
        end
        MODE_ROR: begin
          q_d      = {q_q[0], q_q[WIDTH-1:1]};
          shift_op = 1'b1;
        end
        MODE_LOAD: begin
          q_d   = par_in;
          cnt_d = '0;
        end
        MODE_CLR: begin
          q_d   = '0;
          cnt_d = '0;
        end
        MODE_ASR: begin
          q_d      = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
          shift_op = 1'b1;
        end
        default: ;
      endcase
    end

    // Counter counts operations regardless of direction; LOAD/CLR never
    // set shift_op so they always win over a would-be wrap.
    if (shift_op) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d        = '0;
        frame_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q          <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      q_q          <= q_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign par_out        = q_q;
  assign serial_out_msb = q_q[WIDTH-1];
  assign serial_out_lsb = q_q[0];
  assign bit_cnt        = cnt_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - directed self-checking bench for univ_shift_reg

module tb_univ_shift_reg;

  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_ROL  = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_LOAD = 3'b101;
  localparam logic [2:0] M_CLR  = 3'b110;
  localparam logic [2:0] M_ASR  = 3'b111;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [2:0]       mode;
  logic             serial_in_lsb;
  logic             serial_in_msb;
  logic [WIDTH-1:0] par_in;
  logic [WIDTH-1:0] par_out;
  logic             serial_out_msb;
  logic             serial_out_lsb;
  logic [CNT_W-1:0] bit_cnt;
  logic             frame_done;

  int n_cmp = 0;
  int n_err = 0;

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .mode           (mode),
    .serial_in_lsb  (serial_in_lsb),
    .serial_in_msb  (serial_in_msb),
    .par_in         (par_in),
    .par_out        (par_out),
    .serial_out_msb (serial_out_msb),
    .serial_out_lsb (serial_out_lsb),
    .bit_cnt        (bit_cnt),
    .frame_done     (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] eq,
                             input logic [1:0] ecnt, input logic efd);
    check({tag, ".q"},    32'(par_out),        32'(eq));
    check({tag, ".msb"},  32'(serial_out_msb), 32'(eq[3]));
    check({tag, ".lsb"},  32'(serial_out_lsb), 32'(eq[0]));
    check({tag, ".cnt"},  32'(bit_cnt),        32'(ecnt));
    check({tag, ".fd"},   32'(frame_done),     32'(efd));
  endtask

  // Drive one operation, let it be sampled, then settle 1ns past the edge.
  task automatic op(input logic e, input logic [2:0] m, input logic sl,
                    input logic sm, input logic [3:0] p);
    en            = e;
    mode          = m;
    serial_in_lsb = sl;
    serial_in_msb = sm;
    par_in        = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] sipo_bits;
    logic [3:0] piso_exp_lsb;
    logic [3:0] piso_q [4];
    logic [3:0] rol_q;

    rst_n = 1'b0; en = 1'b0; mode = M_HOLD;
    serial_in_lsb = 1'b0; serial_in_msb = 1'b0; par_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 4'h0, 2'd0, 1'b0);
    rst_n = 1'b1;

    // Build q=4'hA with cnt=1, then reset asynchronously mid-cycle.
    op(1, M_LOAD, 0, 0, 4'h5);
    check_state("pre_load", 4'h5, 2'd0, 1'b0);
    op(1, M_SHL, 0, 0, 4'h0);
    check_state("pre_shl", 4'hA, 2'd1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_state("async_rst", 4'h0, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      op(1, M_HOLD, 1, 1, 4'hF);
      check_state("hold", 4'h0, 2'd0, 1'b0);
    end

    // SIPO: shift in 1,0,1,1
    sipo_bits = 4'b1101;  // bit i is the i-th serial input
    op(1, M_SHL, sipo_bits[0], 0, 0); check_state("sipo1", 4'b0001, 2'd1, 1'b0);
    op(1, M_SHL, sipo_bits[1], 0, 0); check_state("sipo2", 4'b0010, 2'd2, 1'b0);
    op(1, M_SHL, sipo_bits[2], 0, 0); check_state("sipo3", 4'b0101, 2'd3, 1'b0);
    op(1, M_SHL, sipo_bits[3], 0, 0); check_state("sipo4", 4'b1011, 2'd0, 1'b1);
    op(1, M_HOLD, 0, 0, 0);           check_state("sipo_after", 4'b1011, 2'd0, 1'b0);

    // PISO: load 1001, shift right with zero fill
    op(1, M_LOAD, 0, 0, 4'b1001);
    check_state("piso_load", 4'b1001, 2'd0, 1'b0);
    piso_exp_lsb = 4'b1001;  // bit i = lsb before edge i
    piso_q[0] = 4'b0100; piso_q[1] = 4'b0010; piso_q[2] = 4'b0001; piso_q[3] = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("piso_out%0d", i), 32'(serial_out_lsb), 32'(piso_exp_lsb[i]));
      op(1, M_SHR, 1, 0, 4'hF);
      check_state($sformatf("piso%0d", i), piso_q[i], 2'(i + 1), i == 3);
    end

    // Rotate and arithmetic shift
    op(1, M_LOAD, 0, 0, 4'b1000);
    op(1, M_ROL, 0, 0, 0); check_state("rol1", 4'b0001, 2'd1, 1'b0);
    op(1, M_ROR, 0, 0, 0); check_state("ror1", 4'b1000, 2'd2, 1'b0);
    op(1, M_ROR, 0, 0, 0); check_state("ror2", 4'b0100, 2'd3, 1'b0);
    op(1, M_LOAD, 0, 0, 4'b1000);
    op(1, M_ASR, 0, 0, 0); check_state("asr1", 4'b1100, 2'd1, 1'b0);
    op(1, M_ASR, 0, 0, 0); check_state("asr2", 4'b1110, 2'd2, 1'b0);

    // Enable gating
    op(1, M_LOAD, 0, 0, 4'b0011);
    op(1, M_SHL, 0, 0, 0); check_state("en_shl1", 4'b0110, 2'd1, 1'b0);
    op(1, M_SHL, 0, 0, 0); check_state("en_shl2", 4'b1100, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      op(0, M_SHL, 1, 1, 4'hF);
      check_state("en_off", 4'b1100, 2'd2, 1'b0);
    end
    op(1, M_SHL, 1, 0, 0); check_state("en_shl3", 4'b1001, 2'd3, 1'b0);
    op(1, M_SHL, 1, 0, 0); check_state("en_shl4", 4'b0011, 2'd0, 1'b1);
    op(0, M_SHL, 1, 0, 0); check_state("en_off_fd", 4'b0011, 2'd0, 1'b0);

    // LOAD/CLR beat the wrap
    op(1, M_LOAD, 0, 0, 4'h0);
    op(1, M_SHL, 1, 0, 0);
    op(1, M_SHL, 1, 0, 0);
    op(1, M_SHL, 1, 0, 0); check_state("pri_pre", 4'b0111, 2'd3, 1'b0);
    op(1, M_LOAD, 0, 0, 4'h5); check_state("pri_load", 4'h5, 2'd0, 1'b0);
    op(1, M_ROR, 0, 0, 0);
    op(1, M_ROR, 0, 0, 0);
    op(1, M_ROR, 0, 0, 0); check_state("pri_pre2", 4'hA, 2'd3, 1'b0);
    op(1, M_CLR, 0, 0, 0); check_state("pri_clr", 4'h0, 2'd0, 1'b0);

    // Back-to-back frames: pulse every 4th rotate, no dead cycle
    op(1, M_LOAD, 0, 0, 4'b1010);
    rol_q = 4'b1010;
    for (int i = 0; i < 8; i++) begin
      op(1, M_ROL, 0, 0, 0);
      rol_q = {rol_q[2:0], rol_q[3]};
      check_state($sformatf("cont%0d", i), rol_q, 2'((i + 1) % 4), (i % 4) == 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
